// File: rtl/pipe_pc_predict.sv
// Fetch-stage PC unit with a direct-mapped BTB and 2-bit direction counters.
// Optional macro PIPE_PC_PREDICT_STATS_EN adds resolve/mispredict counters.
module pipe_pc_predict #(
  parameter int          BTB_ENTRIES  = 16,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [1:0]  CTR_ALLOC    = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  output logic [31:0] RegPC,
  output logic        Pred_Taken,
  output logic [31:0] Pred_Target,
  input  logic        Resolve_Valid,
  input  logic [31:0] Resolve_PC,
  input  logic        Resolve_Taken,
  input  logic [31:0] Resolve_Target,
  input  logic        Resolve_Pred_Taken,
  input  logic [31:0] Resolve_Pred_Target,
  output logic        Flush,
  output logic        Fault
`ifdef PIPE_PC_PREDICT_STATS_EN
  ,
  output logic [31:0] Stat_Resolved,
  output logic [31:0] Stat_Mispredict
`endif
);

  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int TW = 30 - IW;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TW-1:0]          tag_q    [BTB_ENTRIES];
  logic [31:0]            target_q [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];

  logic [IW-1:0] f_idx, r_idx;
  logic [TW-1:0] f_tag, r_tag;
  logic          f_hit, r_hit;
  logic          mispredict, fault_now, train;

  assign f_idx = RegPC[IW+1:2];
  assign f_tag = RegPC[31:IW+2];
  assign r_idx = Resolve_PC[IW+1:2];
  assign r_tag = Resolve_PC[31:IW+2];

  // Lookup reads the registered table, so a same-cycle write is not visible yet.
  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign Pred_Taken  = f_hit && ctr_q[f_idx][1];
  assign Pred_Target = target_q[f_idx];
  assign r_hit       = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

  assign mispredict = Resolve_Valid &&
                      ((Resolve_Pred_Taken != Resolve_Taken) ||
                       (Resolve_Taken && (Resolve_Pred_Target != Resolve_Target)));
  assign fault_now  = Resolve_Valid && Resolve_Taken && (Resolve_Target[1:0] != 2'b00);
  assign train      = Resolve_Valid && !Fault && !fault_now;
  assign Flush      = mispredict && !Fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      RegPC <= RESET_VECTOR;
      Fault <= 1'b0;
    end else if (Fault) begin
      RegPC <= RegPC;
    end else if (fault_now) begin
      Fault <= 1'b1;
    end else if (mispredict) begin
      RegPC <= Resolve_Taken ? Resolve_Target : Resolve_PC + 32'd4;
    end else if (PCWrite && (RegPC != 32'd0)) begin
      // Address zero is the halt address; fetch parks there.
      RegPC <= Pred_Taken ? Pred_Target : RegPC + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (train) begin
      if (r_hit) begin
        if (Resolve_Taken) begin
          if (ctr_q[r_idx] != 2'b11) ctr_q[r_idx] <= ctr_q[r_idx] + 2'd1;
          target_q[r_idx] <= Resolve_Target;
        end else if (ctr_q[r_idx] != 2'b00) begin
          ctr_q[r_idx] <= ctr_q[r_idx] - 2'd1;
        end
      end else if (Resolve_Taken) begin
        valid_q[r_idx]  <= 1'b1;
        tag_q[r_idx]    <= r_tag;
        target_q[r_idx] <= Resolve_Target;
        ctr_q[r_idx]    <= CTR_ALLOC;
      end
    end
  end

`ifdef PIPE_PC_PREDICT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      Stat_Resolved   <= 32'd0;
      Stat_Mispredict <= 32'd0;
    end else if (!Fault) begin
      if (Resolve_Valid) Stat_Resolved   <= Stat_Resolved + 32'd1;
      if (mispredict)    Stat_Mispredict <= Stat_Mispredict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_pc_predict.sv
// Self-checking bench for pipe_pc_predict: directed sequence then random
// resolves against a table-level reference model.
module tb_pipe_pc_predict;
  localparam int          N  = 16;
  localparam int          IW = 4;
  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset, PCWrite, Resolve_Valid, Resolve_Taken, Resolve_Pred_Taken;
  logic [31:0] Resolve_PC, Resolve_Target, Resolve_Pred_Target;
  logic [31:0] RegPC, Pred_Target;
  logic        Pred_Taken, Flush, Fault;
`ifdef PIPE_PC_PREDICT_STATS_EN
  logic [31:0] Stat_Resolved, Stat_Mispredict;
`endif

  always #5 clk = ~clk;

  pipe_pc_predict dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .RegPC(RegPC),
    .Pred_Taken(Pred_Taken), .Pred_Target(Pred_Target),
    .Resolve_Valid(Resolve_Valid), .Resolve_PC(Resolve_PC),
    .Resolve_Taken(Resolve_Taken), .Resolve_Target(Resolve_Target),
    .Resolve_Pred_Taken(Resolve_Pred_Taken), .Resolve_Pred_Target(Resolve_Pred_Target),
    .Flush(Flush), .Fault(Fault)
`ifdef PIPE_PC_PREDICT_STATS_EN
    , .Stat_Resolved(Stat_Resolved), .Stat_Mispredict(Stat_Mispredict)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  logic [31:0] m_pc;
  bit          m_fault;
  logic [31:0] m_res, m_mis;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int bidx(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[bidx(pc)] && (m_tag[bidx(pc)] == (pc >> (2 + IW)));
  endfunction

  function automatic bit m_ptaken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[bidx(pc)] >= 2);
  endfunction

  task automatic cycle(input bit rst, input bit pcw, input bit rv, input logic [31:0] rpc,
                       input bit rt, input logic [31:0] rtgt, input bit rpt,
                       input logic [31:0] rptgt);
    bit mis, fnow;
    int i;
    @(negedge clk);
    reset = rst; PCWrite = pcw; Resolve_Valid = rv; Resolve_PC = rpc;
    Resolve_Taken = rt; Resolve_Target = rtgt;
    Resolve_Pred_Taken = rpt; Resolve_Pred_Target = rptgt;
    #1;
    mis  = rv && ((rpt != rt) || (rt && (rptgt != rtgt)));
    fnow = rv && rt && (rtgt % 4 != 0);
    chk("regpc", RegPC, m_pc);
    chk("pred_taken", 32'(Pred_Taken), 32'(m_ptaken(m_pc)));
    if (m_valid[bidx(m_pc)]) chk("pred_target", Pred_Target, m_tgt[bidx(m_pc)]);
    chk("flush", 32'(Flush), 32'(mis && !m_fault));
    chk("fault", 32'(Fault), 32'(m_fault));
`ifdef PIPE_PC_PREDICT_STATS_EN
    chk("stat_resolved", Stat_Resolved, m_res);
    chk("stat_mispredict", Stat_Mispredict, m_mis);
`endif
    if (rst) begin
      m_pc = RV; m_fault = 0; m_res = 0; m_mis = 0;
      for (int k = 0; k < N; k++) begin
        m_valid[k] = 0; m_ctr[k] = 1; m_tgt[k] = 0; m_tag[k] = 0;
      end
    end else begin
      if (!m_fault) begin
        if (rv)  m_res = m_res + 1;
        if (mis) m_mis = m_mis + 1;
      end
      if (m_fault) begin
      end else if (fnow) begin
        m_fault = 1;
      end else begin
        if (mis) m_pc = rt ? rtgt : rpc + 4;
        else if (pcw && m_pc != 0) m_pc = m_ptaken(m_pc) ? m_tgt[bidx(m_pc)] : m_pc + 4;
        if (rv) begin
          i = bidx(rpc);
          if (m_hit(rpc)) begin
            if (rt) begin
              m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
              m_tgt[i] = rtgt;
            end else begin
              m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
          end else if (rt) begin
            m_valid[i] = 1; m_tag[i] = rpc >> (2 + IW); m_tgt[i] = rtgt; m_ctr[i] = 2;
          end
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input bit pcw);
    cycle(0, pcw, 0, 32'd0, 0, 32'd0, 0, 32'd0);
  endtask

  task automatic res(input bit pcw, input logic [31:0] rpc, input bit rt,
                     input logic [31:0] rtgt, input bit rpt, input logic [31:0] rptgt);
    cycle(0, pcw, 1, rpc, rt, rtgt, rpt, rptgt);
  endtask

  initial begin
    bit rst, pcw, rv, rt, rpt;
    logic [31:0] rpc, rtgt, rptgt;

    cycle(1, 1, 0, 32'd0, 0, 32'd0, 0, 32'd0);
    #1 chk("tp_reset_pc", RegPC, 32'hBFC00000);
    chk("tp_reset_pred", 32'(Pred_Taken), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      idle(1);
      #1 chk("tp_seq_pc", RegPC, 32'hBFC00000 + 32'(4 * k));
    end
    res(1, 32'hBFC00010, 1, 32'hBFC00100, 0, 32'd0);
    #1 chk("tp_cold_redirect", RegPC, 32'hBFC00100);
    res(1, 32'hBFC0000C, 1, 32'hBFC00010, 0, 32'd0);
    #1 chk("tp_refetch_pc", RegPC, 32'hBFC00010);
    chk("tp_hit_pred", 32'(Pred_Taken), 32'd1);
    chk("tp_hit_target", Pred_Target, 32'hBFC00100);
    idle(1);
    #1 chk("tp_pred_follow", RegPC, 32'hBFC00100);
    res(1, 32'hBFC00010, 1, 32'hBFC00100, 1, 32'hBFC00100);
    #1 chk("tp_correct_pred", RegPC, 32'hBFC00104);
    res(1, 32'hBFC00010, 0, 32'd0, 1, 32'hBFC00100);
    #1 chk("tp_nt1_redirect", RegPC, 32'hBFC00014);
    res(1, 32'hBFC00010, 0, 32'd0, 1, 32'hBFC00100);
    #1 chk("tp_nt2_redirect", RegPC, 32'hBFC00014);
    res(0, 32'hBFC0000C, 0, 32'd0, 1, 32'hBFC00010);
    #1 chk("tp_stall_redirect", RegPC, 32'hBFC00010);
    chk("tp_trained_nt", 32'(Pred_Taken), 32'd0);
    for (int k = 0; k < 3; k++) begin
      idle(0);
      #1 chk("tp_stall_hold", RegPC, 32'hBFC00010);
    end
    res(1, 32'hBFC00014, 1, 32'hFFFFFFFC, 0, 32'd0);
    #1 chk("tp_top_pc", RegPC, 32'hFFFFFFFC);
    idle(1);
    #1 chk("tp_wrap", RegPC, 32'd0);
    idle(1);
    #1 chk("tp_halt", RegPC, 32'd0);
    res(1, 32'hBFC00018, 1, 32'hBFC00102, 0, 32'd0);
    #1 chk("tp_fault_set", 32'(Fault), 32'd1);
    chk("tp_fault_pc", RegPC, 32'd0);
    for (int k = 0; k < 3; k++) res(1, 32'hBFC00010, 1, 32'hBFC00100, 0, 32'd0);
    #1 chk("tp_fault_frozen", RegPC, 32'd0);
    cycle(1, 1, 0, 32'd0, 0, 32'd0, 0, 32'd0);
    #1 chk("tp_reset_clears", 32'(Pred_Taken), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 299) == 0) || (m_fault && $urandom_range(0, 9) == 0);
      pcw   = ($urandom_range(0, 3) != 0);
      rv    = ($urandom_range(0, 2) == 0);
      rpc   = RV + 32'(4 * $urandom_range(0, 63));
      rt    = 1'($urandom_range(0, 1));
      rtgt  = RV + 32'(4 * $urandom_range(0, 63));
      if ($urandom_range(0, 199) == 0) rtgt = rtgt + 32'd2;
      if ($urandom_range(0, 1) == 1) begin
        rpt   = m_ptaken(rpc);
        rptgt = m_tgt[bidx(rpc)];
      end else begin
        rpt   = 1'($urandom_range(0, 1));
        rptgt = RV + 32'(4 * $urandom_range(0, 63));
      end
      cycle(rst, pcw, rv, rpc, rt, rtgt, rpt, rptgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
